// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier datapath.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width for a given operand width.
  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/param_rca.sv
// Ripple-carry adder, optionally approximate in its lower half.
// APPROX=1: the lower WIDTH/2 sum bits are a|b, and the carry into the upper
// half is generated only by the top lower-half bit pair (a&b). The upper half
// is always an exact ripple chain.
module param_rca #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned APPROX = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LOA_BITS = (APPROX != 0) ? int'(WIDTH / 2) : 0;

  logic [WIDTH:0] carry;

  // Bitwise ripple chain; approximate cells replace the low full adders.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i < LOA_BITS) begin
        sum[i]     = a[i] | b[i];
        carry[i+1] = (i == LOA_BITS - 1) ? (a[i] & b[i]) : carry[i];
      end else begin
        sum[i]     = a[i] ^ b[i] ^ carry[i];
        carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one adder step per cycle with
// valid/ready handshakes, operand isolation on zero multiplier bits, and a
// gate_en strobe for the upper-accumulator clock gate.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned APPROX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 gate_en
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [PW-1:0]    p_reg, p_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic [WIDTH-1:0] rca_b;
  logic [WIDTH-1:0] rca_sum;
  logic             rca_cout;

  // Operand isolation: the adder sees zero when the current multiplier bit is 0.
  always_comb begin
    rca_b = '0;
    if (p_reg[0]) begin
      rca_b = a_reg;
    end
  end

  param_rca #(
    .WIDTH  (WIDTH),
    .APPROX (APPROX)
  ) u_rca (
    .a    (p_reg[PW-1:WIDTH]),
    .b    (rca_b),
    .cin  (1'b0),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    p_nxt     = p_reg;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    gate_en   = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_nxt     = a;
          p_nxt     = {{WIDTH{1'b0}}, b};
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        gate_en = p_reg[0];
        if (p_reg[0]) begin
          p_nxt = {rca_cout, rca_sum, p_reg[WIDTH-1:1]};
        end else begin
          p_nxt = {1'b0, p_reg[PW-1:1]};
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            a_nxt     = a;
            p_nxt     = {{WIDTH{1'b0}}, b};
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any work in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      p_reg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      a_reg <= a_nxt;
      p_reg <= p_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign product = p_reg;

endmodule
